// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access sizes, FSM states, alignment rule.
package dmem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_lsu_align.sv
// Combinational store byte-enable/data replication and load extract/extend for one lane.
module lsu_align
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    misaligned = is_misaligned(size, addr_lo);
    shifted    = rdata_raw >> {addr_lo, 3'b000};
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serializes the two LSU lanes onto one single-ported data memory, lane 0 first,
// stalling the pipeline until every op of the bundle has completed.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              advance_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [1:0]        size0_i,
  input  logic [1:0]        size1_i,
  input  logic              uns0_i,
  input  logic              uns1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic              mem_stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        done0, done1;
  logic        pend0, pend1;
  logic        sel;
  logic        a_we, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic        mis;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;
  logic        fin, fin_err, fin_load;
  logic [31:0] fin_rdata;
  state_t      next_after;
  logic        unused;

  assign unused = ^{addr0_i[31:ADDR_W+2], addr1_i[31:ADDR_W+2]};

  assign pend0       = req0_i && !done0;
  assign pend1       = req1_i && !done1;
  assign mem_stall_o = pend0 || pend1;

  always_comb begin
    case (state)
      ST_REQ0, ST_WAIT0: sel = 1'b0;
      ST_REQ1, ST_WAIT1: sel = 1'b1;
      default:           sel = !pend0;
    endcase
    a_we    = sel ? we1_i    : we0_i;
    a_uns   = sel ? uns1_i   : uns0_i;
    a_size  = sel ? size1_i  : size0_i;
    a_addr  = sel ? addr1_i  : addr0_i;
    a_wdata = sel ? wdata1_i : wdata0_i;
  end

  lsu_align u_align (
    .size      (a_size),
    .uns       (a_uns),
    .addr_lo   (a_addr[1:0]),
    .wdata     (a_wdata),
    .rdata_raw (dmem_rdata_i),
    .misaligned(mis),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // Finishing lane 0 chains straight into lane 1's request, skipping IDLE.
  assign next_after = (!sel && pend1) ? ST_REQ1 : ST_IDLE;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_load     = 1'b0;
    fin_rdata    = rdata_ext;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    case (state)
      ST_IDLE: begin
        // A misaligned op is rejected here without ever reaching the memory.
        if (mem_stall_o) begin
          if (mis) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            state_d = next_after;
          end else begin
            state_d = sel ? ST_REQ1 : ST_REQ0;
          end
        end
      end
      ST_REQ0, ST_REQ1: begin
        if (mis) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = next_after;
        end else begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = a_we;
          dmem_addr_o  = a_addr[ADDR_W+1:2];
          dmem_be_o    = a_we ? be : '0;
          dmem_wdata_o = a_we ? wdata_rep : '0;
          if (dmem_ready_i) begin
            if (a_we) begin
              fin     = 1'b1;
              state_d = next_after;
            end else begin
              cnt_d   = '0;
              state_d = sel ? ST_WAIT1 : ST_WAIT0;
            end
          end
        end
      end
      ST_WAIT0, ST_WAIT1: begin
        if (dmem_rvalid_i) begin
          fin      = 1'b1;
          fin_load = 1'b1;
          state_d  = next_after;
        end else if (cnt == 4'(TIMEOUT - 1)) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_load  = 1'b1;
          fin_rdata = '0;
          state_d   = next_after;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata0_o <= '0;
      rdata1_o <= '0;
      err0_o   <= 1'b0;
      err1_o   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (advance_i && !mem_stall_o) begin
        done0 <= 1'b0;
        done1 <= 1'b0;
      end
      if (fin) begin
        if (sel) begin
          done1  <= 1'b1;
          err1_o <= fin_err;
          if (fin_load) rdata1_o <= fin_rdata;
        end else begin
          done0  <= 1'b1;
          err0_o <= fin_err;
          if (fin_load) rdata0_o <= fin_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a byte-level memory reference model.
module tb_dmem_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_i, advance_i;
  logic        req0_i, req1_i, we0_i, we1_i, uns0_i, uns1_i;
  logic [1:0]  size0_i, size1_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [31:0] rdata0_o, rdata1_o;
  logic        err0_o, err1_o, mem_stall_o;
  logic        dmem_req_o, dmem_we_o;
  logic [9:0]  dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  always #5 clock_i = ~clock_i;

  dmem_arbiter #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .advance_i(advance_i),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .size0_i(size0_i), .size1_i(size1_i), .uns0_i(uns0_i), .uns1_i(uns1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .err0_o(err0_o), .err1_o(err1_o),
    .mem_stall_o(mem_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  // Environment memory (written only through DUT requests) and reference byte memory.
  logic [31:0] env_mem [1024];
  logic [7:0]  ref_mem [4096];

  bit          rd_pend, no_rv, env_rand, adv_hold;
  int          rd_delay, nreq, stall_cnt;
  logic [9:0]  rd_addr, first_addr;
  logic [3:0]  first_be;
  logic        first_we;
  bit          first_seen;

  logic        l_req[2], l_we[2], l_uns[2];
  logic [1:0]  l_size[2];
  logic [31:0] l_addr[2], l_wdata[2];
  logic [31:0] exp_rdata[2];
  logic        exp_err[2];
  int          exp_nreq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    env_mem[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  task automatic tick();
    if (rd_pend && !no_rv && rd_delay == 0) begin
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = env_mem[rd_addr];
      rd_pend       = 1'b0;
    end else begin
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;
      if (rd_pend && rd_delay > 0) rd_delay--;
    end
    dmem_ready_i = env_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    advance_i = adv_hold ? 1'b0 : ((env_rand && mem_stall_o) ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    if (mem_stall_o) stall_cnt++;
    if (dmem_req_o && dmem_ready_i) begin
      nreq++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_be   = dmem_be_o;
        first_we   = dmem_we_o;
        first_addr = dmem_addr_o;
      end
      if (dmem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (dmem_be_o[b]) env_mem[dmem_addr_o][8*b +: 8] = dmem_wdata_o[8*b +: 8];
      end else begin
        rd_pend  = 1'b1;
        rd_addr  = dmem_addr_o;
        rd_delay = env_rand ? $urandom_range(0, 3) : 0;
      end
    end
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive();
    req0_i = l_req[0]; we0_i = l_we[0]; size0_i = l_size[0]; uns0_i = l_uns[0];
    addr0_i = l_addr[0]; wdata0_i = l_wdata[0];
    req1_i = l_req[1]; we1_i = l_we[1]; size1_i = l_size[1]; uns1_i = l_uns[1];
    addr1_i = l_addr[1]; wdata1_i = l_wdata[1];
    #1;
  endtask

  task automatic set_lane(input int n, input logic r, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] a, input logic [31:0] d);
    l_req[n] = r; l_we[n] = w; l_size[n] = s; l_uns[n] = u; l_addr[n] = a; l_wdata[n] = d;
  endtask

  // Runs one bundle until the stall drops, optionally holds advance low, then retires it.
  task automatic run(input int hold);
    int n;
    drive();
    stall_cnt = 0; nreq = 0; first_seen = 1'b0; n = 0;
    while (mem_stall_o && n < 60) begin
      tick();
      n++;
    end
    chk("bundle_completes", {31'd0, mem_stall_o}, 32'd0);
    adv_hold = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    adv_hold = 1'b0;
    tick();
    set_lane(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_lane(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    rd_pend = 1'b0;
  endtask

  // Reference: lane 0 then lane 1, byte-granular memory, plain size/sign arithmetic.
  task automatic model_bundle();
    int nb, a;
    logic [31:0] v;
    exp_nreq = 0;
    for (int ln = 0; ln < 2; ln++) begin
      if (l_req[ln]) begin
        nb = 1 << l_size[ln];
        a  = int'(l_addr[ln][11:0]);
        if ((a % nb) != 0) begin
          exp_err[ln] = 1'b1;
        end else begin
          exp_err[ln] = 1'b0;
          exp_nreq++;
          if (l_we[ln]) begin
            for (int i = 0; i < nb; i++) ref_mem[a+i] = l_wdata[ln][8*i +: 8];
          end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (!l_uns[ln] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            exp_rdata[ln] = v;
          end
        end
      end
    end
  endtask

  task automatic check_bundle();
    int w;
    chk("rand_rdata0", rdata0_o, exp_rdata[0]);
    chk("rand_rdata1", rdata1_o, exp_rdata[1]);
    chk("rand_err0", {31'd0, err0_o}, {31'd0, exp_err[0]});
    chk("rand_err1", {31'd0, err1_o}, {31'd0, exp_err[1]});
    chk("rand_nreq", nreq, exp_nreq);
    for (int ln = 0; ln < 2; ln++) begin
      if (l_req[ln] && l_we[ln] && !exp_err[ln]) begin
        w = int'(l_addr[ln][11:2]);
        chk("rand_store_word", env_mem[w],
            {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    reset_i = 1'b1; advance_i = 1'b1;
    dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    rd_pend = 1'b0; no_rv = 1'b0; env_rand = 1'b0; adv_hold = 1'b0;
    set_lane(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_lane(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive();
    for (int w = 0; w < 1024; w++) poke(w, $urandom);
    @(posedge clock_i); #1;
    do_reset();

    chk("reset_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("reset_req", {31'd0, dmem_req_o}, 32'd0);
    chk("reset_rdata0", rdata0_o, 32'd0);
    chk("reset_err1", {31'd0, err1_o}, 32'd0);

    poke(4, 32'hDEADBEEF);
    set_lane(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    run(0);
    chk("lw_stall", stall_cnt, 3);
    chk("lw_rdata", rdata0_o, 32'hDEADBEEF);
    chk("lw_addr", {22'd0, first_addr}, 32'd4);

    set_lane(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB);
    set_lane(1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    run(0);
    chk("sb_lbu_stall", stall_cnt, 4);
    chk("sb_first_we", {31'd0, first_we}, 32'd1);
    chk("sb_first_be", {28'd0, first_be}, 32'h8);
    chk("sb_lbu_rdata1", rdata1_o, 32'h0000_00AB);

    poke(0, 32'h8001_0000);
    set_lane(0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h02, 32'd0);
    set_lane(1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h02, 32'd0);
    run(0);
    chk("lh_lhu_stall", stall_cnt, 5);
    chk("lh_signed", rdata0_o, 32'hFFFF_8001);
    chk("lhu_zero", rdata1_o, 32'h0000_8001);

    set_lane(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h06, 32'd0);
    run(0);
    chk("mis_stall", stall_cnt, 1);
    chk("mis_nreq", nreq, 0);
    chk("mis_err", {31'd0, err0_o}, 32'd1);

    no_rv = 1'b1;
    set_lane(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    run(0);
    no_rv = 1'b0; rd_pend = 1'b0;
    chk("to_stall", stall_cnt, 17);
    chk("to_rdata", rdata0_o, 32'd0);
    chk("to_err", {31'd0, err0_o}, 32'd1);

    set_lane(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    run(4);
    chk("hold_nreq", nreq, 1);
    chk("hold_err_cleared", {31'd0, err0_o}, 32'd0);
    chk("hold_rdata", rdata0_o, 32'hABAD_BEEF);

    no_rv = 1'b1;
    set_lane(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    drive();
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; rd_pend = 1'b0; no_rv = 1'b0;
    chk("rst_wait_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_wait_stall", {31'd0, mem_stall_o}, 32'd1);
    chk("rst_wait_rdata", rdata0_o, 32'd0);
    run(0);
    chk("rst_rerun_rdata", rdata0_o, 32'hABAD_BEEF);

    do_reset();
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    env_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int ln = 0; ln < 2; ln++) begin
        s = 2'($urandom_range(0, 2));
        if (ln == 1 && $urandom_range(0, 2) == 0) a = l_addr[0];
        else a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
        set_lane(ln, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), s,
                 1'($urandom_range(0, 1)), a, $urandom);
      end
      model_bundle();
      run(0);
      check_bundle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
